// File: rtl/ysyx_2022040010_pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: default geometry,
// stage indices for the classic five-stage core and bus typedefs.
package ysyx_2022040010_pipe_ctrl_pkg;

    localparam int DEF_NSTAGE   = 5;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_WDOG_CYC = 1024;

    // Stage indices for the default five-stage pipeline (IF youngest, WB oldest)
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef logic [DEF_NSTAGE-1:0] stall_bus_t;
    typedef logic [DEF_NSTAGE-1:0] flush_bus_t;

endpackage

// File: rtl/ysyx_2022040010_pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module ysyx_2022040010_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; the counter never wraps past all-ones
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_2022040010_pipe_ctrl.sv
// Pipeline control: turns per-stage stall/flush requests into hold, bubble
// and squash controls, tracks stage valid bits, counts events and watches
// for a pipeline that stays stalled too long.
module ysyx_2022040010_pipe_ctrl
    import ysyx_2022040010_pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WDOG_CYC = DEF_WDOG_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic [NSTAGE-1:0] flushreq,
    input  logic              clr_cnt,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic [NSTAGE-1:0] valid,
    output logic              retire,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              wdog_trip
);

    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYC);

    // stall_any[i]: some stage at or above i requests a stall (i <= s)
    // flush_any[i]: some stage at or above i requests a flush (i <= f)
    logic [NSTAGE-1:0] stall_any;
    logic [NSTAGE-1:0] flush_any;
    logic [NSTAGE-1:0] bubble_raw;
    logic [NSTAGE-1:0] valid_nxt;
    logic [NSTAGE-1:0] valid_prev;
    logic              flush_ok;
    logic              any_stall;
    logic [WD_W-1:0]   wd_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_enc
            assign stall_any[gi] = |stallreq[NSTAGE-1:gi];
            assign flush_any[gi] = |flushreq[NSTAGE-1:gi];
            if (gi == 0) begin : g_b0
                assign bubble_raw[gi] = 1'b0;
            end else begin : g_bn
                assign bubble_raw[gi] = stall_any[gi-1] & ~stall_any[gi];
            end
        end
    endgenerate

    // A flush is honoured when some flushing stage sits above every stall (f > s)
    assign flush_ok  = |(flushreq & ~stall_any);
    assign any_stall = |stallreq;

    assign stall  = rst ? stall_any : '0;
    assign bubble = rst ? bubble_raw : '0;
    assign flush  = (rst && flush_ok) ? flush_any : '0;
    assign retire = rst & valid[NSTAGE-1] & ~stall_any[NSTAGE-1];

    assign valid_prev = {valid[NSTAGE-2:0], in_valid};

    // Next valid per stage: squash beats hold, hold beats bubble, else shift in
    always_comb begin
        valid_nxt = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (flush[k]) begin
                valid_nxt[k] = 1'b0;
            end else if (stall[k]) begin
                valid_nxt[k] = valid[k];
            end else if (bubble[k]) begin
                valid_nxt[k] = 1'b0;
            end else begin
                valid_nxt[k] = valid_prev[k];
            end
        end
    end

    // Stage valid register
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else begin
            valid <= valid_nxt;
        end
    end

    // Consecutive-stall run length, parked at WDOG_CYC so it cannot wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (any_stall) begin
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    // Sticky trip at the end of the WDOG_CYC-th consecutive stalled cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_trip <= 1'b0;
        end else if (any_stall && (wd_cnt == WD_LAST)) begin
            wdog_trip <= 1'b1;
        end
    end

    ysyx_2022040010_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (any_stall),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

    ysyx_2022040010_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (|flush),
        .clr (clr_cnt),
        .cnt (flush_cnt)
    );

    ysyx_2022040010_sat_cnt #(.W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .inc (retire),
        .clr (clr_cnt),
        .cnt (retire_cnt)
    );

endmodule

// File: tb/tb_ysyx_2022040010_pipe_ctrl.sv
// Self-checking bench for the pipeline control unit: directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_ysyx_2022040010_pipe_ctrl;

    localparam int NSTAGE   = 5;
    localparam int CNT_W    = 4;
    localparam int WDOG_CYC = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [NSTAGE-1:0] stallreq;
    logic [NSTAGE-1:0] flushreq;
    logic              clr_cnt;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic [NSTAGE-1:0] valid;
    logic              retire;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  retire_cnt;
    logic              wdog_trip;

    int checks = 0;
    int errors = 0;

    logic [NSTAGE-1:0] m_valid;
    int                m_stall_cnt;
    int                m_flush_cnt;
    int                m_retire_cnt;
    int                m_run;
    logic              m_trip;
    logic [NSTAGE-1:0] e_stall;
    logic [NSTAGE-1:0] e_bubble;
    logic [NSTAGE-1:0] e_flush;
    logic              e_retire;

    always #5 clk = ~clk;

    ysyx_2022040010_pipe_ctrl #(
        .NSTAGE   (NSTAGE),
        .CNT_W    (CNT_W),
        .WDOG_CYC (WDOG_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .stallreq   (stallreq),
        .flushreq   (flushreq),
        .clr_cnt    (clr_cnt),
        .stall      (stall),
        .bubble     (bubble),
        .flush      (flush),
        .valid      (valid),
        .retire     (retire),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .retire_cnt (retire_cnt),
        .wdog_trip  (wdog_trip)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic [NSTAGE-1:0] sr,
                                 input logic [NSTAGE-1:0] fr, input logic cc);
        rst      = r;
        in_valid = iv;
        stallreq = sr;
        flushreq = fr;
        clr_cnt  = cc;
    endtask

    // Expected combinational outputs from the highest stall index s and flush index f
    task automatic modelComb();
        int s;
        int f;
        s = -1;
        f = -1;
        for (int i = 0; i < NSTAGE; i++) begin
            if (stallreq[i]) s = i;
            if (flushreq[i]) f = i;
        end
        e_stall  = '0;
        e_bubble = '0;
        e_flush  = '0;
        e_retire = 1'b0;
        if (rst) begin
            for (int i = 0; i < NSTAGE; i++) begin
                e_stall[i] = (i <= s);
                e_flush[i] = (f >= 0) && ((s < 0) || (f > s)) && (i <= f);
            end
            if ((s >= 0) && (s + 1 < NSTAGE)) e_bubble[s+1] = 1'b1;
            e_retire = m_valid[NSTAGE-1] && !e_stall[NSTAGE-1];
        end
    endtask

    // Advance the model state across one clock edge
    task automatic modelEdge();
        logic [NSTAGE-1:0] old;
        old = m_valid;
        if (!rst) begin
            m_valid      = '0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
            m_retire_cnt = 0;
            m_run        = 0;
            m_trip       = 1'b0;
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                if (e_flush[i])       m_valid[i] = 1'b0;
                else if (e_stall[i])  m_valid[i] = old[i];
                else if (e_bubble[i]) m_valid[i] = 1'b0;
                else if (i == 0)      m_valid[i] = in_valid;
                else                  m_valid[i] = old[i-1];
            end
            if (clr_cnt) begin
                m_stall_cnt  = 0;
                m_flush_cnt  = 0;
                m_retire_cnt = 0;
            end else begin
                if ((stallreq != 0) && (m_stall_cnt < CNT_MAX))  m_stall_cnt++;
                if ((e_flush != 0) && (m_flush_cnt < CNT_MAX))   m_flush_cnt++;
                if (e_retire && (m_retire_cnt < CNT_MAX))        m_retire_cnt++;
            end
            if (stallreq != 0) m_run++;
            else               m_run = 0;
            if (m_run >= WDOG_CYC) m_trip = 1'b1;
        end
    endtask

    task automatic compareAll();
        modelComb();
        checkOutput("stall",      32'(stall),      32'(e_stall));
        checkOutput("bubble",     32'(bubble),     32'(e_bubble));
        checkOutput("flush",      32'(flush),      32'(e_flush));
        checkOutput("retire",     32'(retire),     32'(e_retire));
        checkOutput("valid",      32'(valid),      32'(m_valid));
        checkOutput("stall_cnt",  32'(stall_cnt),  32'(m_stall_cnt));
        checkOutput("flush_cnt",  32'(flush_cnt),  32'(m_flush_cnt));
        checkOutput("retire_cnt", 32'(retire_cnt), 32'(m_retire_cnt));
        checkOutput("wdog_trip",  32'(wdog_trip),  32'(m_trip));
    endtask

    task automatic settle();
        #4;
        compareAll();
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic stepCycle();
        settle();
        advance();
    endtask

    initial begin
        logic [NSTAGE-1:0] sr;
        logic [NSTAGE-1:0] fr;

        applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
        m_valid      = '0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
        m_retire_cnt = 0;
        m_run        = 0;
        m_trip       = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset and fill");
        repeat (3) stepCycle();
        settle();
        checkOutput("t1_rst_valid",  32'(valid),  32'(0));
        checkOutput("t1_rst_retire", 32'(retire), 32'(0));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
        repeat (5) stepCycle();
        settle();
        checkOutput("t1_fill_valid",  32'(valid),  32'(5'b11111));
        checkOutput("t1_fill_retire", 32'(retire), 32'(1));
        advance();

        $display("[TB] single-cycle stall");
        applyStimulus(1'b1, 1'b1, 5'b00100, '0, 1'b0);
        settle();
        checkOutput("t2_stall",  32'(stall),  32'(5'b00111));
        checkOutput("t2_bubble", 32'(bubble), 32'(5'b01000));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
        settle();
        checkOutput("t2_valid3",    32'(valid[3]),  32'(0));
        checkOutput("t2_stall_cnt", 32'(stall_cnt), 32'(1));
        advance();

        $display("[TB] flush");
        repeat (5) stepCycle();
        applyStimulus(1'b1, 1'b1, '0, 5'b00100, 1'b0);
        settle();
        checkOutput("t3_flush", 32'(flush), 32'(5'b00111));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
        settle();
        checkOutput("t3_valid_lo",  32'(valid[2:0]), 32'(0));
        checkOutput("t3_valid3",    32'(valid[3]),   32'(1));
        checkOutput("t3_flush_cnt", 32'(flush_cnt),  32'(1));
        advance();

        $display("[TB] flush deferred behind stall");
        applyStimulus(1'b1, 1'b1, 5'b01000, 5'b00100, 1'b0);
        settle();
        checkOutput("t4_flush",  32'(flush),  32'(0));
        checkOutput("t4_stall",  32'(stall),  32'(5'b01111));
        checkOutput("t4_bubble", 32'(bubble), 32'(5'b10000));
        advance();
        applyStimulus(1'b1, 1'b1, '0, 5'b00100, 1'b0);
        settle();
        checkOutput("t4_flush_late", 32'(flush), 32'(5'b00111));
        advance();

        $display("[TB] watchdog");
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 5'b00010, '0, 1'b0);
        repeat (WDOG_CYC - 1) stepCycle();
        settle();
        checkOutput("t5_trip_early", 32'(wdog_trip), 32'(0));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
        settle();
        checkOutput("t5_trip",      32'(wdog_trip), 32'(1));
        checkOutput("t5_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
        settle();
        checkOutput("t5_trip_after_clr", 32'(wdog_trip), 32'(1));
        checkOutput("t5_cnt_after_clr",  32'(stall_cnt), 32'(0));
        advance();

        $display("[TB] retire counter saturation");
        repeat (20) stepCycle();
        settle();
        checkOutput("t6_retire_sat", 32'(retire_cnt), 32'(CNT_MAX));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b1);
        settle();
        checkOutput("t6_retire_live", 32'(retire), 32'(1));
        advance();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
        settle();
        checkOutput("t6_retire_clr", 32'(retire_cnt), 32'(0));
        advance();

        $display("[TB] reset during stall and flush");
        applyStimulus(1'b0, 1'b1, 5'b11111, 5'b11111, 1'b0);
        settle();
        checkOutput("t7_stall",  32'(stall),  32'(0));
        checkOutput("t7_retire", 32'(retire), 32'(0));
        advance();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        settle();
        checkOutput("t7_valid", 32'(valid),     32'(0));
        checkOutput("t7_trip",  32'(wdog_trip), 32'(0));
        advance();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            sr = '0;
            fr = '0;
            for (int i = 0; i < NSTAGE; i++) begin
                sr[i] = ($urandom_range(0, 9) == 0);
                fr[i] = ($urandom_range(0, 11) == 0);
            end
            if (n >= 1500 && n < 1540) sr[1] = 1'b1;
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                          sr, fr, ($urandom_range(0, 49) == 0));
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
